// File: rtl/data_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared definitions for the data-memory responder:
//   - MemRead/MemWrite access-size encoding
//   - responder FSM state encoding
//   - lane count of a RAM word and the alignment rule for an access size
// ---------------------------------------------------------------------------
package data_mem_responder_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  // Byte lanes in one 32-bit RAM word.
  localparam int LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Halves must sit on an even byte, words on a multiple of four.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_HALF: return lane[0];
      SZ_WORD: return (lane != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
// Request/response channels between the core (master) and the data-memory
// responder (slave).
//   req_valid/req_ready   request handshake
//   req_addr, req_wdata   byte address, right-aligned store data
//   MemRead, MemWrite     load/store size (00 none, 01 byte, 10 half, 11 word)
//   req_unsigned          zero-extend sub-word loads
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    load data (0 for stores/errors), illegal-request flag
// ---------------------------------------------------------------------------
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  MemRead;
  logic [1:0]  MemWrite;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wdata, MemRead, MemWrite, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, MemRead, MemWrite, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder_lane_align.sv
// ---------------------------------------------------------------------------
// data_mem_responder_lane_align
// Purely combinational byte-lane steering for one 32-bit RAM word.
//   word        in  32  current RAM word
//   wdata       in  32  right-aligned store data
//   st_size     in  2   store size (SZ_NONE leaves the word unchanged)
//   ld_size     in  2   load size  (SZ_NONE returns 0)
//   lane        in  2   byte lane of the access, little-endian
//   ld_unsigned in  1   zero-extend sub-word loads when 1
//   new_word    out 32  word after merging the store
//   rdata       out 32  extracted and extended load data
// ---------------------------------------------------------------------------
module data_mem_responder_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  st_size,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  lane,
  input  logic        ld_unsigned,
  output logic [31:0] new_word,
  output logic [31:0] rdata
);

  logic [4:0]  byte_off;
  logic [4:0]  half_off;
  logic [31:0] shifted;

  assign byte_off = {lane, 3'b000};
  assign half_off = {lane[1], 4'b0000};
  assign shifted  = word >> byte_off;

  always_comb begin : store_merge
    new_word = word;
    case (st_size)
      SZ_BYTE: new_word[byte_off +: 8]  = wdata[7:0];
      SZ_HALF: new_word[half_off +: 16] = wdata[15:0];
      SZ_WORD: new_word = wdata;
      default: new_word = word;
    endcase
  end

  always_comb begin : load_extract
    rdata = '0;
    case (ld_size)
      SZ_BYTE: rdata = ld_unsigned ? {24'b0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata = ld_unsigned ? {16'b0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      SZ_WORD: rdata = word;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Responder end of the data-memory interface. Accepts one load/store at a
// time, performs it on a word-organised RAM LATENCY cycles after acceptance
// and holds the response until the requester takes it.
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-low reset (RAM contents are kept)
//   bus    slave modport of data_mem_responder_if
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | req_ready=1, waiting for a request
//   ST_BUSY | request captured, latency counter running down to 0
//   ST_RESP | rsp_valid=1, result held until rsp_ready
// ---------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int         LANE_ADDR_BITS = $clog2(LANES);
  localparam int         CAP_BITS       = ADDR_BITS + LANE_ADDR_BITS;
  localparam logic [3:0] LAT_LOAD       = 4'(LATENCY - 1);

  state_t                state;
  state_t                state_next;
  logic [3:0]            cnt;
  logic [CAP_BITS-1:0]   cap_addr;
  logic [31:0]           cap_wdata;
  logic [1:0]            cap_rd;
  logic [1:0]            cap_wr;
  logic                  cap_unsigned;

  logic                  accept;
  logic                  commit;
  logic [ADDR_BITS-1:0]  word_idx;
  logic [1:0]            lane;
  logic [1:0]            acc_size;
  logic                  acc_err;
  logic [31:0]           old_word;
  logic [31:0]           new_word;
  logic [31:0]           ld_data;
  logic                  addr_hi_unused;

  logic [31:0]           mem [2**ADDR_BITS];

  // Address bits above the RAM are ignored, so accesses wrap.
  assign addr_hi_unused = ^bus.req_addr[31:CAP_BITS];

  assign word_idx = cap_addr[CAP_BITS-1:LANE_ADDR_BITS];
  assign lane     = cap_addr[LANE_ADDR_BITS-1:0];
  assign acc_size = (cap_rd != SZ_NONE) ? cap_rd : cap_wr;
  assign acc_err  = ((cap_rd != SZ_NONE) && (cap_wr != SZ_NONE)) || misaligned(acc_size, lane);
  assign old_word = mem[word_idx];

  data_mem_responder_lane_align u_align (
    .word        (old_word),
    .wdata       (cap_wdata),
    .st_size     (cap_wr),
    .ld_size     (cap_rd),
    .lane        (lane),
    .ld_unsigned (cap_unsigned),
    .new_word    (new_word),
    .rdata       (ld_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    accept        = 1'b0;
    commit        = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt == 4'd0) begin
          commit     = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt           <= '0;
      cap_addr      <= '0;
      cap_wdata     <= '0;
      cap_rd        <= SZ_NONE;
      cap_wr        <= SZ_NONE;
      cap_unsigned  <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt          <= LAT_LOAD;
        cap_addr     <= bus.req_addr[CAP_BITS-1:0];
        cap_wdata    <= bus.req_wdata;
        cap_rd       <= bus.MemRead;
        cap_wr       <= bus.MemWrite;
        cap_unsigned <= bus.req_unsigned;
      end else if ((state == ST_BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end

      if (commit) begin
        bus.rsp_err   <= acc_err;
        bus.rsp_rdata <= acc_err ? 32'd0 : ld_data;
      end else if ((state == ST_RESP) && bus.rsp_ready) begin
        bus.rsp_err   <= 1'b0;
        bus.rsp_rdata <= '0;
      end
    end
  end

  // commit is only reachable from ST_BUSY, which reset forces away from,
  // so a store abandoned by reset never reaches the RAM.
  always_ff @(posedge clk) begin
    if (commit && !acc_err && (cap_wr != SZ_NONE)) mem[word_idx] <= new_word;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Self-checking bench for data_mem_responder (ADDR_BITS=8, LATENCY=2).
// The reference memory is a flat little-endian byte array; expected results
// come from byte-level arithmetic on it.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int ADDR_BITS = 8;
  localparam int LATENCY   = 2;
  localparam int MAX_WAIT  = 40;
  localparam int MEM_BYTES = 4 * (2 ** ADDR_BITS);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        uns;
  } req_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  data_mem_responder_if bus ();

  data_mem_responder #(.ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ref_mem [MEM_BYTES];

  function automatic req_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] rd, input logic [1:0] wr, input logic uns);
    req_t r;
    r.addr  = addr;
    r.wdata = wdata;
    r.rd    = rd;
    r.wr    = wr;
    r.uns   = uns;
    return r;
  endfunction

  // Reference: byte-addressed memory, natural alignment, little-endian.
  task automatic model_access(input req_t r, output logic [31:0] exp_rdata, output logic exp_err);
    int          nbytes;
    int          base;
    logic [1:0]  size;
    logic [31:0] v;
    logic [31:0] fill;
    size   = (r.rd != 2'b00) ? r.rd : r.wr;
    nbytes = (size == 2'b01) ? 1 : (size == 2'b10) ? 2 : (size == 2'b11) ? 4 : 0;
    base   = int'(r.addr % MEM_BYTES);
    exp_rdata = 32'd0;
    exp_err   = ((r.rd != 2'b00) && (r.wr != 2'b00)) || ((nbytes > 0) && ((base % nbytes) != 0));
    if (exp_err) return;
    if (r.wr != 2'b00) begin
      for (int i = 0; i < nbytes; i++) begin
        v = r.wdata >> (8 * i);
        ref_mem[base + i] = v[7:0];
      end
    end else if (r.rd != 2'b00) begin
      v = 32'd0;
      for (int i = 0; i < nbytes; i++) v = v | ({24'd0, ref_mem[base + i]} << (8 * i));
      if (!r.uns && (nbytes < 4) && (((v >> (8 * nbytes - 1)) & 32'd1) != 32'd0)) begin
        fill = 32'hFFFF_FFFF << (8 * nbytes);
        v    = v | fill;
      end
      exp_rdata = v;
    end
  endtask

  // Drive one request, wait for its response, hold rsp_ready low for
  // `hold` cycles, then take it. Called away from the clock edge.
  task automatic do_req(input req_t r, input int hold,
                        output logic [31:0] got_rdata, output logic got_err, output int lat);
    int n;
    bus.req_addr     = r.addr;
    bus.req_wdata    = r.wdata;
    bus.MemRead      = r.rd;
    bus.MemWrite     = r.wr;
    bus.req_unsigned = r.uns;
    bus.req_valid    = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < MAX_WAIT) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
    got_rdata = bus.rsp_rdata;
    got_err   = bus.rsp_err;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.MemRead = SZ_NONE; bus.MemWrite = SZ_NONE; bus.req_unsigned = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL reset_handshake req_ready,rsp_valid got=%b exp=10", {bus.req_ready, bus.rsp_valid});
    end
    checks++;
    if ({bus.rsp_err, bus.rsp_rdata} !== 33'd0) begin
      failures++;
      $display("FAIL reset_data err=%b rdata=%h exp 0/00000000", bus.rsp_err, bus.rsp_rdata);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Give every RAM word a known value so later loads never see X.
  task automatic test_fill();
    logic [31:0] got, exp;
    logic        ge, ee;
    int          lat;
    req_t        r;
    for (int w = 0; w < 2 ** ADDR_BITS; w++) begin
      r = mk(32'(w * 4), $urandom, SZ_NONE, SZ_WORD, 1'b0);
      do_req(r, 0, got, ge, lat);
      model_access(r, exp, ee);
      checks++;
      if ({ge, got, lat} !== {ee, exp, LATENCY}) begin
        failures++;
        $display("FAIL fill[%0d] err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d", w, ge, got, lat, ee, exp, LATENCY);
      end
    end
  endtask

  task automatic test_basic_word();
    req_t        q[$];
    logic [31:0] got, exp;
    logic        ge, ee;
    int          lat;
    q.push_back(mk(32'h10, 32'hDEAD_BEEF, SZ_NONE, SZ_WORD, 1'b0));
    q.push_back(mk(32'h10, 32'h0, SZ_WORD, SZ_NONE, 1'b0));
    foreach (q[i]) begin
      do_req(q[i], 0, got, ge, lat);
      model_access(q[i], exp, ee);
      checks++;
      if ({ge, got, lat} !== {ee, exp, LATENCY}) begin
        failures++;
        $display("FAIL basic_word[%0d] err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d", i, ge, got, lat, ee, exp, LATENCY);
      end
    end
  endtask

  task automatic test_byte_ext();
    req_t        q[$];
    logic [31:0] got, exp;
    logic        ge, ee;
    int          lat;
    q.push_back(mk(32'h10, 32'h0, SZ_NONE, SZ_WORD, 1'b0));
    q.push_back(mk(32'h13, 32'h0000_0080, SZ_NONE, SZ_BYTE, 1'b0));
    q.push_back(mk(32'h13, 32'h0, SZ_BYTE, SZ_NONE, 1'b0));
    q.push_back(mk(32'h13, 32'h0, SZ_BYTE, SZ_NONE, 1'b1));
    q.push_back(mk(32'h10, 32'h0, SZ_WORD, SZ_NONE, 1'b0));
    q.push_back(mk(32'h12, 32'h0000_9ABC, SZ_NONE, SZ_HALF, 1'b0));
    q.push_back(mk(32'h12, 32'h0, SZ_HALF, SZ_NONE, 1'b0));
    q.push_back(mk(32'h12, 32'h0, SZ_HALF, SZ_NONE, 1'b1));
    foreach (q[i]) begin
      do_req(q[i], 0, got, ge, lat);
      model_access(q[i], exp, ee);
      checks++;
      if ({ge, got, lat} !== {ee, exp, LATENCY}) begin
        failures++;
        $display("FAIL byte_ext[%0d] err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d", i, ge, got, lat, ee, exp, LATENCY);
      end
    end
  endtask

  task automatic test_misalign_conflict_noop();
    req_t        q[$];
    logic [31:0] got, exp;
    logic        ge, ee;
    int          lat;
    q.push_back(mk(32'h11, 32'h0, SZ_HALF, SZ_NONE, 1'b0));
    q.push_back(mk(32'h12, 32'h1234_5678, SZ_NONE, SZ_WORD, 1'b0));
    q.push_back(mk(32'h11, 32'h0000_FFFF, SZ_NONE, SZ_HALF, 1'b0));
    q.push_back(mk(32'h10, 32'h0, SZ_WORD, SZ_NONE, 1'b0));
    q.push_back(mk(32'h10, 32'h5555_AAAA, SZ_WORD, SZ_WORD, 1'b0));
    q.push_back(mk(32'h10, 32'h0, SZ_WORD, SZ_NONE, 1'b0));
    q.push_back(mk(32'h10, 32'h7777_7777, SZ_NONE, SZ_NONE, 1'b0));
    q.push_back(mk(32'h10, 32'h0, SZ_WORD, SZ_NONE, 1'b0));
    foreach (q[i]) begin
      do_req(q[i], 0, got, ge, lat);
      model_access(q[i], exp, ee);
      checks++;
      if ({ge, got, lat} !== {ee, exp, LATENCY}) begin
        failures++;
        $display("FAIL misalign_conflict[%0d] err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d", i, ge, got, lat, ee, exp, LATENCY);
      end
    end
  endtask

  task automatic test_backpressure();
    req_t        r;
    logic [31:0] exp;
    logic        ee;
    int          lat;
    r = mk(32'h10, 32'h0, SZ_WORD, SZ_NONE, 1'b0);
    model_access(r, exp, ee);
    bus.req_addr = r.addr; bus.req_wdata = r.wdata; bus.MemRead = r.rd;
    bus.MemWrite = r.wr; bus.req_unsigned = r.uns; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
    // req_valid stays high while the response is pending: it must be ignored.
    checks++;
    if (lat !== LATENCY) begin
      failures++;
      $display("FAIL backpressure_latency got=%0d exp=%0d", lat, LATENCY);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, ee, exp}) begin
        failures++;
        $display("FAIL backpressure_hold[%0d] valid=%b ready=%b err=%b rdata=%h exp 1/0/%b/%h",
                 c, bus.rsp_valid, bus.req_ready, bus.rsp_err, bus.rsp_rdata, ee, exp);
      end
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL backpressure_release ready=%b valid=%b err=%b rdata=%h exp 1/0/0/00000000",
               bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
  endtask

  task automatic test_wrap();
    req_t        q[$];
    logic [31:0] got, exp;
    logic        ge, ee;
    int          lat;
    q.push_back(mk(32'h400, 32'hA5A5_A5A5, SZ_NONE, SZ_WORD, 1'b0));
    q.push_back(mk(32'h000, 32'h0, SZ_WORD, SZ_NONE, 1'b0));
    q.push_back(mk(32'hFFFF_F3FD, 32'h0000_00C3, SZ_NONE, SZ_BYTE, 1'b0));
    q.push_back(mk(32'h3FC, 32'h0, SZ_WORD, SZ_NONE, 1'b0));
    foreach (q[i]) begin
      do_req(q[i], 0, got, ge, lat);
      model_access(q[i], exp, ee);
      checks++;
      if ({ge, got, lat} !== {ee, exp, LATENCY}) begin
        failures++;
        $display("FAIL wrap[%0d] err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d", i, ge, got, lat, ee, exp, LATENCY);
      end
    end
  endtask

  task automatic test_reset_midbusy();
    req_t        r;
    logic [31:0] got, exp;
    logic        ge, ee;
    int          lat;
    bus.req_addr = 32'h20; bus.req_wdata = 32'h0BAD_F00D; bus.MemRead = SZ_NONE;
    bus.MemWrite = SZ_WORD; bus.req_unsigned = 1'b0; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b00) begin
      failures++;
      $display("FAIL midbusy_in_flight ready=%b valid=%b exp 0/0", bus.req_ready, bus.rsp_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL midbusy_async_reset ready=%b valid=%b err=%b rdata=%h exp 1/0/0/00000000",
               bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    r = mk(32'h20, 32'h0, SZ_WORD, SZ_NONE, 1'b0);
    do_req(r, 0, got, ge, lat);
    model_access(r, exp, ee);
    checks++;
    if ({ge, got, lat} !== {ee, exp, LATENCY}) begin
      failures++;
      $display("FAIL midbusy_store_dropped err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d", ge, got, lat, ee, exp, LATENCY);
    end
  endtask

  task automatic test_random();
    req_t        r;
    logic [31:0] got, exp;
    logic        ge, ee;
    int          lat;
    int          kind;
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 9));
      r.addr  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      r.wdata = $urandom;
      r.uns   = 1'($urandom_range(0, 1));
      if (kind == 0) begin
        r.rd = 2'($urandom_range(1, 3)); r.wr = 2'($urandom_range(1, 3));
      end else if (kind == 1) begin
        r.rd = SZ_NONE; r.wr = SZ_NONE;
      end else if (kind < 6) begin
        r.rd = 2'($urandom_range(1, 3)); r.wr = SZ_NONE;
      end else begin
        r.rd = SZ_NONE; r.wr = 2'($urandom_range(1, 3));
      end
      do_req(r, int'($urandom_range(0, 3)), got, ge, lat);
      model_access(r, exp, ee);
      checks++;
      if ({ge, got, lat} !== {ee, exp, LATENCY}) begin
        failures++;
        $display("FAIL random[%0d] addr=%h rd=%b wr=%b uns=%b err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d",
                 n, r.addr, r.rd, r.wr, r.uns, ge, got, lat, ee, exp, LATENCY);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic_word();
    test_byte_ext();
    test_misalign_conflict_noop();
    test_backpressure();
    test_wrap();
    test_reset_midbusy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
